// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter.
// Optional feature macro: IMEM_ARB_PERF_COUNTERS_EN (per-requester grant/wait counters).
package imem_arb_pkg;

    // Width of each performance counter
    localparam int PERF_CNT_W = 32;

    // Requester-index width: a single requester still needs one tag bit
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // LSB of requester idx's slice in a flattened address bus
    function automatic int addr_lsb(input int idx, input int aw);
        return idx * aw;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous tag FIFO: remembers which requester issued each outstanding read.
// Push when full and pop when empty are ignored.
module arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state: pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Control state is reset; storage contents need not be
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among NUM_REQ
// fetch units. Ready depends only on registered state and mem_ready, so there
// is no combinational loop through a requester's read strobe. Responses are
// returned in order to their issuer using a tag FIFO.
// Optional: define IMEM_ARB_PERF_COUNTERS_EN to add perf_grants / perf_wait.
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_read_address,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_valid,
    output logic [DATA_WIDTH-1:0]           req_out_data,
    output logic [ADDRESS_BITS-1:0]         req_out_addr,
    output logic                            mem_read,
    output logic [ADDRESS_BITS-1:0]         mem_read_address,
    input  logic                            mem_ready,
    input  logic                            mem_valid,
    input  logic [DATA_WIDTH-1:0]           mem_out_data,
    input  logic [ADDRESS_BITS-1:0]         mem_out_addr,
    output logic                            resp_error
`ifdef IMEM_ARB_PERF_COUNTERS_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0]   perf_grants,
    output logic [NUM_REQ*PERF_CNT_W-1:0]   perf_wait
`endif
);

    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [TAG_W-1:0] owner_q, owner_d;
    logic             resp_error_q, resp_error_d;
    logic             accept;
    logic             pop;
    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;

    // Responses are broadcast; only req_valid is steered
    assign req_out_data = mem_out_data;
    assign req_out_addr = mem_out_addr;
    assign mem_read     = accept;
    assign resp_error   = resp_error_q;

    // Grant the owner only; mux the owner's address to memory
    always_comb begin
        req_ready        = '0;
        mem_read_address = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == TAG_W'(i)) begin
                req_ready[i]     = ~reset & mem_ready & ~fifo_full;
                mem_read_address = req_read_address[addr_lsb(i, ADDRESS_BITS) +: ADDRESS_BITS];
            end
        end
        accept = |(req_read & req_ready);
    end

    // Pop on any response while tags are outstanding; steer valid by head tag
    always_comb begin
        pop       = mem_valid & ~fifo_empty & ~reset;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = pop & (head_tag == TAG_W'(i));
        end
    end

    // Owner rotates every cycle regardless of accept; orphan responses latch the error
    always_comb begin
        owner_d      = (owner_q == TAG_W'(NUM_REQ - 1)) ? '0 : owner_q + TAG_W'(1);
        resp_error_d = resp_error_q | (mem_valid & fifo_empty);
    end

    // Owner pointer and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q      <= '0;
            resp_error_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            resp_error_q <= resp_error_d;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (owner_q),
        .pop       (pop),
        .pop_data  (head_tag),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IMEM_ARB_PERF_COUNTERS_EN
    logic [PERF_CNT_W-1:0] grants_q [NUM_REQ];
    logic [PERF_CNT_W-1:0] grants_d [NUM_REQ];
    logic [PERF_CNT_W-1:0] wait_q   [NUM_REQ];
    logic [PERF_CNT_W-1:0] wait_d   [NUM_REQ];

    // Count accepts and stalled-read cycles per requester; wrap naturally
    always_comb begin
        perf_grants = '0;
        perf_wait   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grants_d[i] = grants_q[i] + PERF_CNT_W'(req_read[i] & req_ready[i]);
            wait_d[i]   = wait_q[i] + PERF_CNT_W'(req_read[i] & ~req_ready[i]);
            perf_grants[i*PERF_CNT_W +: PERF_CNT_W] = grants_q[i];
            perf_wait[i*PERF_CNT_W +: PERF_CNT_W]   = wait_q[i];
        end
    end

    // Performance counter registers
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                grants_q[i] <= '0;
                wait_q[i]   <= '0;
            end else begin
                grants_q[i] <= grants_d[i];
                wait_q[i]   <= wait_d[i];
            end
        end
    end
`endif

    // Occupancy is observable only through full/empty at this level
    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares one instruction-memory / I-cache read port between NUM_REQ fetch units (one per core in multi-core builds).
- Sits between the fetch units' i_mem_* interfaces and the single memory port.
- Grants the port round-robin using a registered owner pointer. No requester's ready depends on its own read, so there is no loop with read = fetch & ready & ~stall.
- Returns in-order responses to the requester that issued each read, using a tag FIFO.

Parameters:
- NUM_REQ, 2, number of fetch requesters (1..8).
- DATA_WIDTH, 32, instruction width.
- ADDRESS_BITS, 20, word-address width.
- MAX_OUTSTANDING, 4, tag FIFO depth (power of 2, ≥2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_read  in  NUM_REQ  per-requester read strobe
- req_read_address  in  NUM_REQ*ADDRESS_BITS  flattened word addresses; requester i occupies bits [i*ADDRESS_BITS +: ADDRESS_BITS]
- req_ready  out  NUM_REQ  per-requester port-available indication
- req_valid  out  NUM_REQ  response valid for requester i
- req_out_data  out  DATA_WIDTH  response data, broadcast to all requesters
- req_out_addr  out  ADDRESS_BITS  response word address, broadcast
- mem_read  out  1  read strobe to memory
- mem_read_address  out  ADDRESS_BITS  address to memory
- mem_ready  in  1  memory can accept a read this cycle
- mem_valid  in  1  memory response valid
- mem_out_data  in  DATA_WIDTH  memory response data
- mem_out_addr  in  ADDRESS_BITS  address of the response
- resp_error  out  1  sticky flag: response arrived with no outstanding tag

Behaviour:
- Reset:
  - owner=0, FIFO empty (count=0), resp_error=0.
  - All req_ready=0, req_valid=0, mem_read=0 while reset is high.
- Ready:
  - req_ready[i] = ~reset & (owner==i) & mem_ready & (count<MAX_OUTSTANDING).
  - Depends only on registered state and mem_ready.
- Issue:
  - accept = req_read[owner] & req_ready[owner].
  - mem_read = accept.
  - mem_read_address = owner's address slice, muxed combinationally (0-cycle latency).
  - req_read from a non-owner is ignored; that requester sees ready=0 and re-presents its read.
- Owner advance:
  - Every non-reset cycle, owner <= (owner+1) mod NUM_REQ, whether or not accept occurred.
  - Worst-case wait is NUM_REQ-1 cycles.
  - With NUM_REQ=1, owner stays 0 and the port is fully pipelined.
- Tag FIFO:
  - On accept, push owner's index; tag width is max(1, clog2(NUM_REQ)).
  - On mem_valid with count>0, pop the head tag; req_valid[head]=1 in the same cycle.
  - req_out_data/req_out_addr are wired straight from mem_out_data/mem_out_addr.
- Ordering: memory is required to return responses in request order, with at least 1 cycle of latency.
- Simultaneous push and pop: both happen; count unchanged; pointers wrap modulo MAX_OUTSTANDING.
- Full: ready is gated by the registered count, so there is no accept when full, even if a pop occurs the same cycle.
- Empty with mem_valid: response dropped, all req_valid=0, resp_error<=1 (cleared only by reset).
- Reset mid-operation: FIFO cleared. Responses from reads issued before reset are dropped and set resp_error; integration resets memory in the same cycle.
- Fetch redirects need no special handling: each fetch unit filters responses by req_out_addr.

Optional Feature:
- Macro: IMEM_ARB_PERF_COUNTERS_EN.
- When defined, adds output perf_grants [NUM_REQ*32] and output perf_wait [NUM_REQ*32].
  - perf_grants: per-requester 32-bit count of accepts.
  - perf_wait: per-requester 32-bit count of cycles with req_read[i]=1 but req_ready[i]=0.
  - Both zeroed on reset and wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (imem_arb_pkg):
  - function computing tag width as max(1, clog2(n));
  - per-requester address-slice helper;
  - localparam PERF_CNT_W = 32.
- Sub-module arb_tag_fifo:
  - synchronous FIFO of tags with push, pop, count, full and empty;
  - parameters DEPTH and WIDTH;
  - instantiated once.

Test Plan:
- Single requester, NUM_REQ=1, mem_ready=1, 1-cycle memory: reads at addresses 0x00,0x01,0x02 on consecutive cycles -> mem_read high 3 cycles; req_valid[0] on cycles 2-4 with req_out_addr 0x00,0x01,0x02.
- NUM_REQ=2, both requesters reading continuously (req0 at 0x10, req1 at 0x80) -> grants alternate 0,1,0,1; each response routed only to its issuer; no response to the wrong requester.
- MAX_OUTSTANDING=4, memory withholding mem_valid -> after 4 accepts all req_ready=0. One mem_valid -> count drops to 3 and ready returns on the next owner cycle.
- mem_valid with empty FIFO (address 0x55) -> all req_valid=0; resp_error=1 and stays 1 until reset.
- Reset asserted with 2 outstanding reads -> the next cycle has count=0, owner=0, all outputs 0. A late mem_valid sets resp_error and does not assert any req_valid.
- With IMEM_ARB_PERF_COUNTERS_EN defined: 10 cycles of two-requester contention -> perf_grants {5,5}; perf_wait equals each requester's non-owner cycles with req_read high.
